// File: rtl/spram_rd_pkg.sv
// rtl/spram_rd_pkg.sv - shared types, constants and address helper for the SRAM stream reader
//
// Purpose : FSM state encoding, read-buffer geometry and the wrapping address adder
//           used by spram_stream_reader and spram_rd_fifo.
// Contents: state_t        IDLE / RUN / DRAIN
//           FIFO_DEPTH     words the read buffer can hold
//           FIFO_CNT_W     width of the buffer occupancy count
//           FIFO_PTR_W     width of the buffer read/write pointers
//           addr_add_wrap  (addr + inc) modulo 2**w_word
package spram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Address increment that wraps inside a 2**w_word word space.
  function automatic logic [31:0] addr_add_wrap(input logic [31:0] addr,
                                                input logic [31:0] inc,
                                                input int          w_word);
    logic [31:0] mask;
    mask = (w_word >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w_word) - 32'd1);
    return (addr + inc) & mask;
  endfunction

endpackage

// File: rtl/spram_rd_fifo.sv
// rtl/spram_rd_fifo.sv - small read-data buffer of {last, data} entries with occupancy count
//
// Purpose : Holds words returned by the SRAM until the downstream stream accepts them.
//           Push and pop in the same cycle leave the count unchanged.
// Ports   : clk        in   clock, posedge
//           rst        in   synchronous active-high reset; empties the buffer, clears storage
//           push       in   write {push_last, push_data}
//           push_data  in   W_DATA word to store
//           push_last  in   end-of-transfer tag stored with the word
//           pop        in   discard the head entry
//           head_data  out  data of the oldest entry
//           head_last  out  last tag of the oldest entry
//           count      out  number of stored entries
//           empty      out  no entries stored
module spram_rd_fifo
  import spram_rd_pkg::*;
#(
  parameter int W_DATA = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W_DATA-1:0]     push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [W_DATA-1:0]     head_data,
  output logic                  head_last,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [W_DATA:0]           mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]     wr_ptr;
  logic [FIFO_PTR_W-1:0]     rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  function automatic logic [FIFO_PTR_W-1:0] ptr_next(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
  endfunction

  // Pop of an empty buffer is ignored; a push into a full buffer is only taken when the
  // head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign {head_last, head_data} = mem[rd_ptr];
  assign empty                  = (count == '0);

endmodule

// File: rtl/spram_stream_reader.sv
// rtl/spram_stream_reader.sv - block reader from single-port SRAM to a valid/ready stream
//
// Purpose : On start, reads len words beginning at base_addr from the SRAM and emits them
//           in order on the m_* stream, absorbing the RAM's 1-cycle read latency and any
//           downstream backpressure through a 2-entry buffer.
// Config  : SPRAM_RD_STRIDE_EN - when defined, a stride port is added and latched on start;
//           the address advances by stride per read (stride 0 rereads base_addr). When not
//           defined the address advances by 1.
// Ports   : clk        in   clock, posedge
//           rst        in   synchronous active-high reset; aborts a transfer without done
//           start      in   1-cycle request, accepted only while idle
//           base_addr  in   W_WORD first word address
//           len        in   W_LEN number of words (0 gives an immediate done)
//           stride     in   W_WORD address increment (SPRAM_RD_STRIDE_EN only)
//           busy       out  transfer in progress
//           done       out  1-cycle pulse after the last word is accepted
//           mem_en     out  RAM enable (read)
//           mem_we     out  RAM write enable, tied low
//           mem_addr   out  W_WORD RAM word address
//           mem_dout   in   W_DATA RAM read data, valid the cycle after mem_en
//           m_valid    out  stream word valid
//           m_ready    in   stream accept
//           m_data     out  W_DATA stream word
//           m_last     out  final word of the transfer
module spram_stream_reader
  import spram_rd_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int W_WORD = 4,
  parameter int W_LEN  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_WORD-1:0] base_addr,
  input  logic [W_LEN-1:0]  len,
`ifdef SPRAM_RD_STRIDE_EN
  input  logic [W_WORD-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [W_WORD-1:0] mem_addr,
  input  logic [W_DATA-1:0] mem_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_DATA-1:0] m_data,
  output logic              m_last
);

  localparam int OCC_W = FIFO_CNT_W + 1;

  state_t                  state;
  logic [W_LEN-1:0]        reads_left;
  logic [W_WORD-1:0]       addr_q;
  logic [W_WORD-1:0]       inc_q;
  logic                    rd_pending;
  logic                    pend_last;
  logic                    done_q;

  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic                    fifo_empty;
  logic                    pop;
  logic                    issue;
  logic [OCC_W-1:0]        occ;

  // occ is what the buffer will have committed once this cycle's pop leaves and the
  // pending read lands. Issuing is allowed only while that leaves room for one more word,
  // so the buffer can never overflow even if m_ready drops right after. Counting the pop
  // is what keeps 1 word/cycle with m_ready held high; it makes mem_en depend on m_ready
  // combinationally.
  always_comb begin
    pop   = !fifo_empty && m_ready;
    occ   = OCC_W'(fifo_count) + OCC_W'(rd_pending) - OCC_W'(pop);
    issue = (state == RUN) && (reads_left != '0) && (occ < OCC_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      reads_left <= '0;
      addr_q     <= '0;
      rd_pending <= 1'b0;
      pend_last  <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPRAM_RD_STRIDE_EN
      inc_q      <= W_WORD'(1);
`endif
    end else begin
      done_q     <= 1'b0;
      // RAM data is only valid the cycle after an issue; the tag travels with it.
      rd_pending <= issue;
      pend_last  <= issue && (reads_left == W_LEN'(1));

      case (state)
        IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            reads_left <= len;
`ifdef SPRAM_RD_STRIDE_EN
            inc_q      <= stride;
`endif
            if (len != '0) begin
              state <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q     <= W_WORD'(addr_add_wrap(32'(addr_q), 32'(inc_q), W_WORD));
            reads_left <= reads_left - W_LEN'(1);
            if (reads_left == W_LEN'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SPRAM_RD_STRIDE_EN
  assign inc_q = W_WORD'(1);
`endif

  spram_rd_fifo #(
    .W_DATA (W_DATA)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending),
    .push_data (mem_dout),
    .push_last (pend_last),
    .pop       (pop),
    .head_data (m_data),
    .head_last (m_last),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign mem_en   = issue;
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;
  assign m_valid  = !fifo_empty;

endmodule

// File: tb/tb_spram_stream_reader.sv
// tb/tb_spram_stream_reader.sv - self-checking bench for spram_stream_reader
module tb_spram_stream_reader;

  localparam int N_WORD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  len = '0;
  logic        busy, done, mem_en, mem_we, m_valid, m_last;
  logic [3:0]  mem_addr;
  logic [31:0] mem_dout = '0;
  logic [31:0] m_data;
  logic        m_ready = 1'b0;

`ifdef SPRAM_RD_STRIDE_EN
  localparam bit STRIDE_ON = 1'b1;
  logic [3:0] stride = 4'd1;
`else
  localparam bit STRIDE_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  spram_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef SPRAM_RD_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  // SRAM: registered read, output held while not enabled.
  logic [31:0] ram [N_WORD];
  always @(posedge clk) if (mem_en) mem_dout <= ram[mem_addr];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: expected read addresses and stream words of a transfer.
  logic [3:0]  addr_q [$];
  logic [32:0] word_q [$];

  task automatic push_expected(input logic [3:0] b, input logic [4:0] l, input int inc);
    for (int i = 0; i < int'(l); i++) begin
      logic [3:0] a;
      a = 4'((int'(b) + i * inc) % N_WORD);
      addr_q.push_back(a);
      word_q.push_back({(i == int'(l) - 1), ram[a]});
    end
  endtask

  // Monitor state
  logic        mon_en = 1'b0;
  logic        zero_start = 1'b0;
  logic        zero_prev = 1'b0;
  logic        last_pop_prev = 1'b0;
  logic        hold_prev = 1'b0;
  logic [32:0] prev_word = '0;
  logic        done_seen = 1'b0;
  logic [3:0]  last_issue_addr = '0;
  int          issued_n = 0;
  int          accepted_n = 0;
  int          xfer_words = 0;

  always @(negedge clk) begin : mon
    logic exp_d;
    logic popped_last;
    if (mon_en) begin
      popped_last = 1'b0;
      if (mem_en) begin
        chk("mem_we", mem_we, 0);
        issued_n++;
        last_issue_addr = mem_addr;
        if (addr_q.size() == 0) fail_now("unexpected_mem_en");
        else chk("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (hold_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_word", {m_last, m_data}, prev_word);
      end
      if (m_valid && m_ready) begin
        accepted_n++;
        xfer_words++;
        popped_last = m_last;
        if (word_q.size() == 0) fail_now("unexpected_word");
        else chk("stream_word", {m_last, m_data}, word_q.pop_front());
      end
      if (!m_ready) chk("buffered_le2", ((issued_n - accepted_n) <= 2), 1);
      exp_d = last_pop_prev | zero_prev;
      if (done || exp_d) chk("done", done, exp_d);
      if (done) done_seen = 1'b1;
      hold_prev     = m_valid & !m_ready;
      prev_word     = {m_last, m_data};
      last_pop_prev = popped_last;
      zero_prev     = zero_start;
    end
  end

  task automatic clear_model();
    addr_q.delete();
    word_q.delete();
    issued_n = 0;
    accepted_n = 0;
    last_pop_prev = 1'b0;
    zero_prev = 1'b0;
    hold_prev = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for stall_n cycles once
  // stall_at words have been accepted. poke pulses a second start while busy.
  task automatic run_transfer(input logic [3:0] b, input logic [4:0] l, input logic [3:0] s,
                              input int mode, input int stall_at, input int stall_n,
                              input bit poke);
    int inc;
    int budget;
    int stalled;
    inc = STRIDE_ON ? int'(s) : 1;
    xfer_words = 0;
    done_seen = 1'b0;
    @(posedge clk); #1;
`ifdef SPRAM_RD_STRIDE_EN
    stride = s;
`endif
    start = 1'b1;
    base_addr = b;
    len = l;
    zero_start = (l == 0);
    push_expected(b, l, inc);
    @(posedge clk); #1;
    start = 1'b0;
    zero_start = 1'b0;
    budget = 60 * (int'(l) + 2) + 20;
    stalled = 0;
    for (int c = 0; c < budget && !done_seen; c++) begin
      case (mode)
        1: m_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (xfer_words >= stall_at && stalled < stall_n) begin
            m_ready = 1'b0;
            stalled++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
      if (poke && c == 2) begin
        start = 1'b1;
        base_addr = 4'd9;
        len = 5'd3;
`ifdef SPRAM_RD_STRIDE_EN
        stride = 4'd2;
`endif
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    m_ready = 1'b1;
    chk("done_within_budget", done_seen, 1);
    chk("addr_q_drained", addr_q.size(), 0);
    chk("word_q_drained", word_q.size(), 0);
    chk("xfer_words", xfer_words, l);
  endtask

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    logic [3:0] stride;
    int         mode;
    int         stall_at;
    int         stall_n;
    logic [3:0] exp_last_addr;
    int         exp_words;
  } vec_t;

  vec_t tbl [5];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [8:0] e_en, e_val, e_last, e_done, e_busy;

    tbl[0] = '{4'd3,  5'd4,  4'd1, 0, 0, 0, 4'd6,  4};
    tbl[1] = '{4'd14, 5'd4,  4'd1, 0, 0, 0, 4'd1,  4};
    tbl[2] = '{4'd0,  5'd6,  4'd1, 2, 2, 5, 4'd5,  6};
    tbl[3] = '{4'd15, 5'd1,  4'd1, 1, 0, 0, 4'd15, 1};
    tbl[4] = '{4'd9,  5'd20, 4'd1, 1, 0, 0, 4'd12, 20};

    for (int i = 0; i < N_WORD; i++) ram[i] = $urandom;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    mon_en = 1'b1;

    // base=3 len=4 with ready high: cycle-exact latency and throughput.
    e_en   = 9'b000011110;
    e_val  = 9'b001111000;
    e_last = 9'b001000000;
    e_done = 9'b010000000;
    e_busy = 9'b001111110;
    xfer_words = 0;
    done_seen = 1'b0;
    push_expected(4'd3, 5'd4, 1);
`ifdef SPRAM_RD_STRIDE_EN
    stride = 4'd1;
`endif
    start = 1'b1;
    base_addr = 4'd3;
    len = 5'd4;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("seq_mem_en[%0d]", i), mem_en, e_en[i]);
      chk($sformatf("seq_m_valid[%0d]", i), m_valid, e_val[i]);
      chk($sformatf("seq_m_last[%0d]", i), m_last, e_last[i]);
      chk($sformatf("seq_done[%0d]", i), done, e_done[i]);
      chk($sformatf("seq_busy[%0d]", i), busy, e_busy[i]);
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("seq_words", xfer_words, 4);
    chk("seq_addr_q_drained", addr_q.size(), 0);

    // Table of transfers: wrap, backpressure, single word, long multi-wrap.
    for (int i = 0; i < 5; i++) begin
      run_transfer(tbl[i].base, tbl[i].len, tbl[i].stride, tbl[i].mode,
                   tbl[i].stall_at, tbl[i].stall_n, 1'b0);
      chk($sformatf("tbl%0d_last_addr", i), last_issue_addr, tbl[i].exp_last_addr);
      chk($sformatf("tbl%0d_words", i), xfer_words, tbl[i].exp_words);
    end

    // Zero-length transfer: done next cycle, no RAM access, no stream word.
    run_transfer(4'd5, 5'd0, 4'd1, 0, 0, 0, 1'b0);
    chk("len0_busy", busy, 0);

    // Strided / start-while-busy.
`ifdef SPRAM_RD_STRIDE_EN
    run_transfer(4'd1, 5'd5, 4'd4, 0, 0, 0, 1'b1);
    chk("stride_last_addr", last_issue_addr, 4'd1);
    run_transfer(4'd6, 5'd3, 4'd0, 1, 0, 0, 1'b0);
    chk("stride0_last_addr", last_issue_addr, 4'd6);
`else
    run_transfer(4'd1, 5'd5, 4'd1, 0, 0, 0, 1'b1);
    chk("poke_last_addr", last_issue_addr, 4'd5);
`endif

    // Reset in the middle of a stalled transfer.
    @(posedge clk); #1;
    m_ready = 1'b0;
`ifdef SPRAM_RD_STRIDE_EN
    stride = 4'd1;
`endif
    push_expected(4'd3, 5'd8, 1);
    start = 1'b1;
    base_addr = 4'd3;
    len = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    clear_model();
    done_seen = 1'b0;
    mon_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_seen, 0);
    run_transfer(4'd10, 5'd7, 4'd1, 0, 0, 0, 1'b0);
    chk("post_reset_last_addr", last_issue_addr, 4'd0);

    // Randomized transfers against the model.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] b, s;
      logic [4:0] l;
      int mode;
      b = 4'($urandom_range(0, 15));
      l = 5'($urandom_range(0, 31));
      s = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 2);
      run_transfer(b, l, s, mode, $urandom_range(0, 4), $urandom_range(1, 6),
                   (l >= 5'd4) && ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
